// File: rtl/pdp8_mem_initiator_pkg.sv
// Shared definitions for the PDP-8 memory-bus initiator: word sizes, the
// queued command record and the initiator FSM state codes.
package pdp8_mem_initiator_pkg;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned WORD_W = 12;

  typedef struct packed {
    logic              write;
    logic              rtype;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } mem_cmd_t;

  typedef logic [1:0] init_state_t;

  localparam init_state_t IDLE = 2'd0;
  localparam init_state_t REQ  = 2'd1;
  localparam init_state_t RESP = 2'd2;
  localparam init_state_t GAP  = 2'd3;

endpackage

// File: rtl/pdp8_mem_initiator_if.sv
// Client request/response handshake plus the memory-controller bus, bundled
// so the initiator, clients and responder models share one connection.
interface pdp8_mem_initiator_if
  import pdp8_mem_initiator_pkg::*;
  ();

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic              req_type;
  logic [ADDR_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [WORD_W-1:0] rsp_rdata;
  logic              rsp_write;
  logic              rsp_error;

  logic [ADDR_W-1:0] address;
  logic [WORD_W-1:0] write_data;
  logic              write_enable;
  logic              read_enable;
  logic              read_type;
  logic [WORD_W-1:0] read_data;
  logic              mem_finished;

  modport master (
    input  req_valid, req_write, req_type, req_addr, req_wdata,
    input  rsp_ready, read_data, mem_finished,
    output req_ready, rsp_valid, rsp_rdata, rsp_write, rsp_error,
    output address, write_data, write_enable, read_enable, read_type
  );

  modport slave (
    output req_valid, req_write, req_type, req_addr, req_wdata,
    output rsp_ready, read_data, mem_finished,
    input  req_ready, rsp_valid, rsp_rdata, rsp_write, rsp_error,
    input  address, write_data, write_enable, read_enable, read_type
  );

endinterface

// File: rtl/pdp8_mem_initiator_mem_req_fifo.sv
// Synchronous command FIFO; DEPTH must be a power of two so the pointers
// wrap naturally.
module mem_req_fifo
  import pdp8_mem_initiator_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   resetN,
  input  logic                   push,
  input  logic                   pop,
  input  mem_cmd_t               din,
  output mem_cmd_t               dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  mem_cmd_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  always_comb begin
    full    = (count == (AW+1)'(DEPTH));
    empty   = (count == '0);
    do_push = push && !full;
    do_pop  = pop && !empty;
    dout    = mem[rd_ptr];
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/pdp8_mem_initiator.sv
// Bus-master end of the PDP-8 memory handshake: queues client commands,
// runs each through REQ/RESP/GAP with a watchdog, and returns a response.
module pdp8_mem_initiator
  import pdp8_mem_initiator_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                        clock,
  input  logic                        resetN,
  pdp8_mem_initiator_if.master        bus,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;

  init_state_t       state;
  mem_cmd_t          cmd;
  mem_cmd_t          head;
  mem_cmd_t          req_cmd;
  logic [TW-1:0]     timer;
  logic [WORD_W-1:0] rdata_q;
  logic              error_q;
  logic              live;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  always_comb begin
    req_cmd = '{write: bus.req_write, rtype: bus.req_type,
                addr: bus.req_addr, wdata: bus.req_wdata};
    push    = bus.req_valid && bus.req_ready;
    pop     = (state == IDLE) && !empty;
  end

  mem_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock  (clock),
    .resetN (resetN),
    .push   (push),
    .pop    (pop),
    .din    (req_cmd),
    .dout   (head),
    .full   (full),
    .empty  (empty),
    .count  (fifo_count)
  );

  // live holds req_ready low on the reset edge itself, not just after it.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      state   <= IDLE;
      cmd     <= '0;
      timer   <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
      live    <= 1'b0;
    end else begin
      live <= 1'b1;
      case (state)
        IDLE: begin
          timer <= '0;
          if (!empty) begin
            cmd   <= head;
            state <= REQ;
          end
        end
        REQ: begin
          timer <= timer + 1'b1;
          if (bus.mem_finished) begin
            rdata_q <= cmd.write ? '0 : bus.read_data;
            error_q <= 1'b0;
            state   <= RESP;
          end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            rdata_q <= '0;
            error_q <= 1'b1;
            state   <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) state <= GAP;
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.req_ready    = live && !full;
    bus.rsp_valid    = (state == RESP);
    bus.rsp_rdata    = rdata_q;
    bus.rsp_write    = cmd.write;
    bus.rsp_error    = error_q;
    bus.address      = cmd.addr;
    bus.write_data   = cmd.wdata;
    bus.write_enable = (state == REQ) && cmd.write;
    bus.read_enable  = (state == REQ) && !cmd.write;
    bus.read_type    = (state == REQ) && cmd.rtype;
    busy             = (state != IDLE) || (fifo_count != '0);
  end

endmodule

// File: tb/tb_pdp8_mem_initiator.sv
// Directed bench for pdp8_mem_initiator: a latency-programmable responder,
// a transaction-level scoreboard checked every cycle, and literal spot checks.
module tb_pdp8_mem_initiator;
  import pdp8_mem_initiator_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int TO = 64;

  logic       clock = 1'b0;
  logic       resetN = 1'b0;
  logic       busy;
  logic [2:0] fifo_count;

  pdp8_mem_initiator_if bus ();

  pdp8_mem_initiator #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .clock      (clock),
    .resetN     (resetN),
    .bus        (bus),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, got, got, want, want);
    end
  endtask

  typedef struct {
    logic        w;
    logic        t;
    logic [11:0] a;
    logic [11:0] d;
    logic [11:0] rdata;
    logic        err;
    int          len;
  } exp_t;

  typedef struct {
    logic [11:0] a;
    logic [11:0] rdata;
    logic        err;
    logic        wr;
    logic        rt;
    int          len;
    int          cyc;
  } obs_t;

  exp_t        exq[$];
  obs_t        hist[$];
  int          lat_q[$];
  logic [11:0] ref_mem [4096];
  logic [11:0] ram [4096];

  int   cyc = 0;
  int   inflight = 0;
  bit   gap_flag = 0;
  int   req_len = 0;
  bit   prev_v = 0;
  logic last_rt = 1'b0;
  int   drv_lat = 1;
  int   acc_cyc = 0;
  int   req_start_cyc = 0;
  logic stray = 1'b0;

  // Responder: finishes the N-th REQ cycle, N taken per transaction (0 = never).
  int resp_cnt = 0;
  int cur_lat = 0;
  always @(negedge clock) begin
    logic fin;
    fin = 1'b0;
    if (bus.write_enable || bus.read_enable) begin
      if (resp_cnt == 0) cur_lat = (lat_q.size() != 0) ? lat_q.pop_front() : 0;
      resp_cnt++;
      fin = (cur_lat != 0) && (resp_cnt == cur_lat);
      if (fin && bus.write_enable) ram[bus.address] = bus.write_data;
    end else begin
      resp_cnt = 0;
    end
    bus.read_data    = fin ? ram[bus.address] : 12'o6666;
    bus.mem_finished = fin || stray;
  end

  // Scoreboard: checks current outputs, then applies what the next edge commits.
  always @(negedge clock) begin
    logic en;
    exp_t e;
    cyc++;
    if (!resetN) begin
      exq.delete();
      lat_q.delete();
      inflight = 0;
      gap_flag = 0;
      req_len  = 0;
      prev_v   = 0;
    end else begin
      en = bus.write_enable || bus.read_enable;
      chk("enables_exclusive", {31'd0, bus.write_enable && bus.read_enable}, 0);
      chk("busy", {31'd0, busy}, {31'd0, inflight != 0});
      if (en) begin
        if (exq.size() == 0) chk("unexpected_req", 1, 0);
        else begin
          chk("address", {20'd0, bus.address}, {20'd0, exq[0].a});
          chk("write_data", {20'd0, bus.write_data}, {20'd0, exq[0].d});
          chk("write_enable", {31'd0, bus.write_enable}, {31'd0, exq[0].w});
          chk("read_type", {31'd0, bus.read_type}, {31'd0, exq[0].t});
        end
        if (req_len == 0) req_start_cyc = cyc;
        req_len++;
        last_rt = bus.read_type;
      end
      if (bus.rsp_valid) begin
        chk("rsp_enables_low", {31'd0, en}, 0);
        if (exq.size() == 0) chk("unexpected_rsp", 1, 0);
        else begin
          e = exq[0];
          chk("rsp_rdata", {20'd0, bus.rsp_rdata}, {20'd0, e.rdata});
          chk("rsp_write", {31'd0, bus.rsp_write}, {31'd0, e.w});
          chk("rsp_error", {31'd0, bus.rsp_error}, {31'd0, e.err});
          if (!prev_v) begin
            chk("req_length", req_len, e.len);
            hist.push_back('{a: bus.address, rdata: bus.rsp_rdata, err: bus.rsp_error,
                             wr: bus.rsp_write, rt: last_rt, len: req_len, cyc: cyc});
            req_len = 0;
          end
        end
      end
      prev_v = bus.rsp_valid;
      if (gap_flag) begin
        inflight--;
        gap_flag = 0;
      end
      if (bus.rsp_valid && bus.rsp_ready && exq.size() != 0) begin
        void'(exq.pop_front());
        gap_flag = 1;
      end
      if (bus.req_valid && bus.req_ready) begin
        e.w   = bus.req_write;
        e.t   = bus.req_type;
        e.a   = bus.req_addr;
        e.d   = bus.req_wdata;
        e.err = (drv_lat < 1) || (drv_lat > TO);
        e.len = e.err ? TO : drv_lat;
        e.rdata = (e.w || e.err) ? 12'd0 : ref_mem[e.a];
        if (e.w && !e.err) ref_mem[e.a] = e.d;
        exq.push_back(e);
        lat_q.push_back(drv_lat);
        inflight++;
        acc_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic w, input logic t, input logic [11:0] a,
                      input logic [11:0] d, input int l);
    bit ok;
    ok = 0;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_type  = t;
    bus.req_addr  = a;
    bus.req_wdata = d;
    drv_lat       = l;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (bus.req_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("send_accepted", 0, 1);
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clock);
      if (exq.size() == 0 && !busy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk(nm, 0, 1);
    tick();
  endtask

  initial begin
    int n0;
    int bad;
    bit seen;
    logic [11:0] v_rdata;
    logic v_write, v_err;

    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_type  = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4096; i++) begin
      ram[i]     = 12'(i * 5 + 3);
      ref_mem[i] = 12'(i * 5 + 3);
    end

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_req_ready", {31'd0, bus.req_ready}, 0);
    chk("reset_busy", {31'd0, busy}, 0);
    chk("reset_rsp_valid", {31'd0, bus.rsp_valid}, 0);
    chk("reset_enables", {30'd0, bus.write_enable, bus.read_enable}, 0);
    chk("reset_fifo_count", {29'd0, fifo_count}, 0);
    chk("reset_address", {20'd0, bus.address}, 0);
    tick();
    resetN = 1'b1;
    tick();
    tick();
    @(negedge clock);
    chk("post_reset_req_ready", {31'd0, bus.req_ready}, 1);
    tick();

    // Reset while a write to 0o0100 is stuck in REQ.
    n0 = hist.size();
    send(1'b1, 1'b0, 12'o0100, 12'o5555, 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (bus.write_enable) begin
        seen = 1;
        break;
      end
    end
    chk("midreq_write_seen", {31'd0, seen}, 1);
    tick();
    resetN = 1'b0;
    tick();
    resetN = 1'b1;
    @(negedge clock);
    chk("midreq_we_dropped", {31'd0, bus.write_enable}, 0);
    chk("midreq_rsp_valid", {31'd0, bus.rsp_valid}, 0);
    chk("midreq_fifo_count", {29'd0, fifo_count}, 0);
    chk("midreq_busy", {31'd0, busy}, 0);
    repeat (12) tick();
    chk("midreq_no_response", hist.size(), n0);
    chk("midreq_mem_untouched", {20'd0, ram[12'o0100]}, {20'd0, 12'(12'o0100 * 5 + 3)});

    // Write with a 3-cycle responder.
    send(1'b1, 1'b0, 12'o0200, 12'o7777, 3);
    drain("write_drain");
    chk("write_accept_to_req", req_start_cyc - acc_cyc, 2);
    chk("write_req_cycles", hist[hist.size()-1].len, 3);
    chk("write_rsp_write", {31'd0, hist[hist.size()-1].wr}, 1);
    chk("write_rsp_error", {31'd0, hist[hist.size()-1].err}, 0);
    chk("write_mem", {20'd0, ram[12'o0200]}, 12'o7777);

    // Read with read_type=1; memory has since been changed by another master.
    ram[12'o0200]     = 12'o1234;
    ref_mem[12'o0200] = 12'o1234;
    send(1'b0, 1'b1, 12'o0200, 12'o0000, 2);
    drain("read_drain");
    chk("read_rdata", {20'd0, hist[hist.size()-1].rdata}, 12'o1234);
    chk("read_type_seen", {31'd0, hist[hist.size()-1].rt}, 1);
    chk("read_rsp_error", {31'd0, hist[hist.size()-1].err}, 0);

    // Five back-to-back requests against a stalled client.
    n0 = hist.size();
    bus.rsp_ready = 1'b0;
    send(1'b1, 1'b0, 12'd0, 12'o4321, 1);
    send(1'b1, 1'b0, 12'd1, 12'o0017, 1);
    send(1'b0, 1'b0, 12'd2, 12'o0000, 1);
    send(1'b0, 1'b1, 12'd3, 12'o0000, 1);
    send(1'b0, 1'b0, 12'd4095, 12'o0000, 1);
    @(negedge clock);
    chk("b2b_fifo_full_count", {29'd0, fifo_count}, 4);
    chk("b2b_req_ready_low", {31'd0, bus.req_ready}, 0);
    chk("b2b_first_rsp_valid", {31'd0, bus.rsp_valid}, 1);
    v_rdata = bus.rsp_rdata;
    v_write = bus.rsp_write;
    v_err   = bus.rsp_error;
    bad = 0;
    repeat (10) begin
      @(negedge clock);
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== v_rdata || bus.rsp_write !== v_write ||
          bus.rsp_error !== v_err || bus.write_enable || bus.read_enable || fifo_count !== 3'd4)
        bad++;
    end
    chk("stall_stable_cycles_bad", bad, 0);
    tick();
    bus.rsp_ready = 1'b1;
    drain("b2b_drain");
    chk("b2b_response_count", hist.size() - n0, 5);
    if (hist.size() >= n0 + 5) begin
      chk("b2b_order_0", {20'd0, hist[n0].a}, 0);
      chk("b2b_order_3", {20'd0, hist[n0+3].a}, 3);
      chk("b2b_order_4", {20'd0, hist[n0+4].a}, 4095);
      chk("b2b_read2_rdata", {20'd0, hist[n0+2].rdata}, 13);
    end
    chk("b2b_mem0", {20'd0, ram[0]}, 12'o4321);

    // Hung responder, then a normal read behind it.
    ram[12'o0301]     = 12'o2345;
    ref_mem[12'o0301] = 12'o2345;
    n0 = hist.size();
    send(1'b0, 1'b0, 12'o0300, 12'o0000, 0);
    send(1'b0, 1'b0, 12'o0301, 12'o0000, 2);
    drain("timeout_drain");
    chk("timeout_response_count", hist.size() - n0, 2);
    if (hist.size() >= n0 + 2) begin
      chk("timeout_error", {31'd0, hist[n0].err}, 1);
      chk("timeout_req_cycles", hist[n0].len, 64);
      chk("timeout_rdata_zero", {20'd0, hist[n0].rdata}, 0);
      chk("after_timeout_error", {31'd0, hist[n0+1].err}, 0);
      chk("after_timeout_rdata", {20'd0, hist[n0+1].rdata}, 12'o2345);
    end

    // Finish on the last legal cycle wins; one cycle later is a timeout.
    n0 = hist.size();
    send(1'b0, 1'b0, 12'o7777, 12'o0000, 64);
    send(1'b0, 1'b0, 12'o7776, 12'o0000, 65);
    drain("edge_drain");
    chk("edge_response_count", hist.size() - n0, 2);
    if (hist.size() >= n0 + 2) begin
      chk("finish_at_limit_error", {31'd0, hist[n0].err}, 0);
      chk("finish_at_limit_cycles", hist[n0].len, 64);
      chk("finish_at_limit_rdata", {20'd0, hist[n0].rdata}, 4094);
      chk("finish_late_error", {31'd0, hist[n0+1].err}, 1);
    end

    // Stray completion strobes while idle.
    stray = 1'b1;
    bad = 0;
    repeat (3) begin
      @(negedge clock);
      if (bus.rsp_valid || busy) bad++;
    end
    tick();
    stray = 1'b0;
    tick();
    chk("stray_finish_ignored", bad, 0);

    // Best-case throughput.
    n0 = hist.size();
    send(1'b1, 1'b0, 12'd10, 12'o0101, 1);
    send(1'b1, 1'b0, 12'd11, 12'o0202, 1);
    send(1'b0, 1'b0, 12'd10, 12'o0000, 1);
    drain("tput_drain");
    chk("tput_response_count", hist.size() - n0, 3);
    if (hist.size() >= n0 + 3) begin
      chk("tput_spacing_1", hist[n0+1].cyc - hist[n0].cyc, 4);
      chk("tput_spacing_2", hist[n0+2].cyc - hist[n0+1].cyc, 4);
      chk("tput_readback", {20'd0, hist[n0+2].rdata}, 12'o0101);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "time limit");
  end

endmodule
